// File: rtl/trans_arbiter.sv
// Round-robin arbiter sharing one trans_validator between N_REQ transaction sources,
// with per-transaction outcome reporting, saturating statistics and a hang watchdog.
module trans_arbiter #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 32768
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable_i,
  input  logic [N_REQ-1:0]           req_valid_i,
  input  logic [128*N_REQ-1:0]       req_data_i,
  output logic [N_REQ-1:0]           req_ready_o,
  output logic [127:0]               v_data_o,
  output logic                       v_valid_o,
  input  logic                       v_ack_i,
  input  logic                       v_accept_i,
  output logic                       res_valid_o,
  output logic                       res_accepted_o,
  output logic [$clog2(N_REQ)-1:0]   res_src_o,
  output logic [127:0]               res_data_o,
  output logic                       busy_o,
  output logic                       timeout_o,
  output logic [31:0]                cnt_accepted_o,
  output logic [31:0]                cnt_rejected_o
);

  localparam int unsigned DW    = 128;
  localparam int unsigned SRC_W = $clog2(N_REQ);
  localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  state_t            state_q;
  logic [SRC_W-1:0]  rr_q;
  logic [SRC_W-1:0]  src_q;
  logic [DW-1:0]     data_q;
  logic              acc_q;
  logic [WD_W-1:0]   wd_q;

  logic [DW-1:0]     req_word_c [N_REQ];
  logic              grant_found_c;
  logic [SRC_W-1:0]  grant_idx_c;
  logic [SRC_W-1:0]  rr_next_c;
  logic              done_c;
  logic              to_c;
  logic              fin_acc_c;

  for (genvar g = 0; g < N_REQ; g++) begin : g_word
    assign req_word_c[g] = req_data_i[g*DW +: DW];
  end

  // First valid requester at or after the rr pointer, wrapping at N_REQ
  always_comb begin
    logic [SRC_W:0] sum;
    logic [SRC_W:0] nxt;
    grant_found_c = 1'b0;
    grant_idx_c   = '0;
    sum           = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      sum = {1'b0, rr_q} + (SRC_W+1)'(i);
      if (sum >= (SRC_W+1)'(N_REQ)) sum = sum - (SRC_W+1)'(N_REQ);
      if (!grant_found_c && req_valid_i[sum[SRC_W-1:0]]) begin
        grant_found_c = 1'b1;
        grant_idx_c   = sum[SRC_W-1:0];
      end
    end
    nxt       = {1'b0, grant_idx_c} + (SRC_W+1)'(1);
    rr_next_c = (nxt == (SRC_W+1)'(N_REQ)) ? '0 : nxt[SRC_W-1:0];
  end

  // Completion has priority over the watchdog when both land on the same cycle
  always_comb begin
    done_c    = (state_q == WAIT_DONE) && v_ack_i;
    to_c      = !done_c && ((state_q == WAIT_BUSY) || (state_q == WAIT_DONE)) &&
                (wd_q == WD_W'(TIMEOUT - 1));
    fin_acc_c = done_c && (acc_q || v_accept_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      rr_q           <= '0;
      src_q          <= '0;
      data_q         <= '0;
      acc_q          <= 1'b0;
      wd_q           <= '0;
      req_ready_o    <= '0;
      v_data_o       <= '0;
      v_valid_o      <= 1'b0;
      res_valid_o    <= 1'b0;
      res_accepted_o <= 1'b0;
      res_src_o      <= '0;
      res_data_o     <= '0;
      busy_o         <= 1'b0;
      timeout_o      <= 1'b0;
      cnt_accepted_o <= '0;
      cnt_rejected_o <= '0;
    end else begin
      req_ready_o <= '0;
      v_valid_o   <= 1'b0;
      res_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (enable_i && grant_found_c) begin
            req_ready_o <= N_REQ'(1) << grant_idx_c;
            data_q      <= req_word_c[grant_idx_c];
            src_q       <= grant_idx_c;
            rr_q        <= rr_next_c;
            busy_o      <= 1'b1;
            state_q     <= ISSUE;
          end
        end
        ISSUE: begin
          if (v_ack_i) begin
            v_valid_o <= 1'b1;
            v_data_o  <= data_q;
            wd_q      <= '0;
            acc_q     <= 1'b0;
            state_q   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY, WAIT_DONE: begin
          if (done_c || to_c) begin
            res_valid_o    <= 1'b1;
            res_accepted_o <= fin_acc_c;
            res_src_o      <= src_q;
            res_data_o     <= data_q;
            acc_q          <= 1'b0;
            busy_o         <= 1'b0;
            state_q        <= IDLE;
            if (to_c) timeout_o <= 1'b1;
            if (fin_acc_c) begin
              if (cnt_accepted_o != '1) cnt_accepted_o <= cnt_accepted_o + 32'd1;
            end else begin
              if (cnt_rejected_o != '1) cnt_rejected_o <= cnt_rejected_o + 32'd1;
            end
          end else begin
            wd_q <= wd_q + WD_W'(1);
            if (v_accept_i) acc_q <= 1'b1;
            // ack is still high the cycle after capture, so only a low ack means started
            if ((state_q == WAIT_BUSY) && !v_ack_i) state_q <= WAIT_DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trans_arbiter.sv
// Self-checking bench for trans_arbiter: requester queues, a behavioural validator
// and a round-robin scoreboard, driven by a directed sequence with random data.
module tb_trans_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 64;

  logic             clk;
  logic             rst;
  logic             enable_i;
  logic [N-1:0]     req_valid_i;
  logic [128*N-1:0] req_data_i;
  logic [N-1:0]     req_ready_o;
  logic [127:0]     v_data_o;
  logic             v_valid_o;
  logic             v_ack_i;
  logic             v_accept_i;
  logic             res_valid_o;
  logic             res_accepted_o;
  logic [1:0]       res_src_o;
  logic [127:0]     res_data_o;
  logic             busy_o;
  logic             timeout_o;
  logic [31:0]      cnt_accepted_o;
  logic [31:0]      cnt_rejected_o;

  trans_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .v_data_o(v_data_o), .v_valid_o(v_valid_o), .v_ack_i(v_ack_i), .v_accept_i(v_accept_i),
    .res_valid_o(res_valid_o), .res_accepted_o(res_accepted_o), .res_src_o(res_src_o),
    .res_data_o(res_data_o), .busy_o(busy_o), .timeout_o(timeout_o),
    .cnt_accepted_o(cnt_accepted_o), .cnt_rejected_o(cnt_rejected_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { int src; logic [127:0] data; bit acc; bit to; } exp_t;

  int total = 0;
  int bad   = 0;

  logic [127:0] rq [N][$];
  exp_t         exp_q[$];
  exp_t         e;
  int           glog[$];
  int           tb_rr = 0;
  logic [31:0]  m_acc = 0, m_rej = 0;
  bit           m_to = 0;
  int           n_issued = 0, n_results = 0, n_accpulse = 0, cyc = 0;
  int           issue_cyc = 0, result_cyc = 0;
  logic [127:0] last_res;
  bit           last_acc;
  int           last_src;
  logic [N-1:0] prev_valid = '0;
  int           vphase = 0, vbusy = 0;
  bit           cap_acc = 0, v_hang = 0, ack_hold = 0;

  function automatic bit accepts(input logic [127:0] d);
    return d[63:32] <= 32'd100;
  endfunction

  function automatic logic [127:0] mk(input logic [7:0] s, input logic [7:0] r,
                                      input logic [31:0] amt, input bit b9);
    return {64'h0, amt, s, r, 6'b0, b9, 9'b0};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string p);
    chk({p, "_ready"}, req_ready_o, 0);
    chk({p, "_vdata"}, v_data_o, 0);
    chk({p, "_vvalid"}, v_valid_o, 0);
    chk({p, "_resv"}, res_valid_o, 0);
    chk({p, "_resacc"}, res_accepted_o, 0);
    chk({p, "_ressrc"}, res_src_o, 0);
    chk({p, "_resdata"}, res_data_o, 0);
    chk({p, "_busy"}, busy_o, 0);
    chk({p, "_timeout"}, timeout_o, 0);
    chk({p, "_cntacc"}, cnt_accepted_o, 0);
    chk({p, "_cntrej"}, cnt_rejected_o, 0);
  endtask

  task automatic wait_res(input int target, input int budget);
    int c = 0;
    while (n_results < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    total++;
    assert (n_results >= target) else begin
      bad++;
      $error("FAIL wait_res: results=%0d expected=%0d", n_results, target);
    end
  endtask

  task automatic set_enable(input logic en);
    @(negedge clk);
    #2 enable_i = en;
  endtask

  // Environment: scoreboard checks, validator model and requester queues
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      exp_q.delete();
      for (int k = 0; k < N; k++) rq[k].delete();
      req_valid_i = '0;
      req_data_i  = '0;
      prev_valid  = '0;
      vphase = 0; v_ack_i = 1'b1; v_accept_i = 1'b0;
      m_acc = 0; m_rej = 0; m_to = 0; tb_rr = 0;
      n_issued = 0; n_results = 0;
    end else begin
      if (req_ready_o != '0) begin
        int k, ek, best;
        k = -1; ek = -1; best = N;
        for (int j = 0; j < N; j++) if (req_ready_o[j]) k = j;
        for (int j = 0; j < N; j++) begin
          if (prev_valid[j] && ((j - tb_rr + N) % N) < best) begin
            best = (j - tb_rr + N) % N;
            ek = j;
          end
        end
        chk("grant_onehot", $countones(req_ready_o), 1);
        chk("grant_enable", enable_i, 1);
        chk("grant_src", k, ek);
        glog.push_back(k);
        if (k >= 0 && rq[k].size() > 0)
          exp_q.push_back('{k, rq[k][0], v_hang ? 1'b0 : accepts(rq[k][0]), v_hang});
        tb_rr = (k + 1) % N;
      end
      if (v_valid_o) begin
        chk("valid_while_ack", v_ack_i, 1);
        chk("one_outstanding", n_issued - n_results, 0);
        chk("v_data", v_data_o, (exp_q.size() > 0) ? exp_q[0].data : 128'hx);
        n_issued++;
        issue_cyc = cyc;
      end
      if (v_accept_i) n_accpulse++;
      if (res_valid_o) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $error("FAIL spurious_result: got src %0d expected no result", res_src_o);
        end else begin
          e = exp_q.pop_front();
          if (e.acc) begin if (m_acc != '1) m_acc++; end
          else begin if (m_rej != '1) m_rej++; end
          if (e.to) m_to = 1'b1;
          chk("res_src", res_src_o, e.src);
          chk("res_data", res_data_o, e.data);
          chk("res_accepted", res_accepted_o, e.acc);
          chk("cnt_accepted", cnt_accepted_o, m_acc);
          chk("cnt_rejected", cnt_rejected_o, m_rej);
          chk("timeout_flag", timeout_o, m_to);
        end
        last_res = res_data_o; last_acc = res_accepted_o; last_src = int'(res_src_o);
        n_results++;
        result_cyc = cyc;
      end
      // Validator: ack high when idle, stays high one cycle after capture, then busy
      v_accept_i = 1'b0;
      case (vphase)
        0: if (v_valid_o && v_ack_i) begin
             cap_acc = accepts(v_data_o);
             vphase = 1;
           end else v_ack_i = !ack_hold;
        1: begin
             vphase = 2;
             vbusy = $urandom_range(3, 7);
           end
        default: begin
          v_ack_i = 1'b0;
          if (v_hang) cap_acc = 1'b0;
          else begin
            vbusy--;
            if (vbusy == 1) v_accept_i = cap_acc;
            if (vbusy == 0) begin v_ack_i = 1'b1; vphase = 0; end
          end
        end
      endcase
      for (int k = 0; k < N; k++)
        if (req_ready_o[k] && rq[k].size() > 0) void'(rq[k].pop_front());
      for (int k = 0; k < N; k++) begin
        req_valid_i[k] = rq[k].size() > 0;
        req_data_i[k*128 +: 128] = (rq[k].size() > 0) ? rq[k][0] : 128'h0;
      end
      prev_valid = req_valid_i;
    end
  end

  initial begin
    int base, pulses, issued, c;
    rst = 1'b1; enable_i = 1'b1; v_ack_i = 1'b1; v_accept_i = 1'b0;
    req_valid_i = '0; req_data_i = '0;
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Single accepted transfer from requester 0
    base = n_results;
    rq[0].push_back(mk(1, 2, 50, 1));
    wait_res(base + 1, 100);
    chk("s1_cnt_acc", cnt_accepted_o, 1);
    chk("s1_cnt_rej", cnt_rejected_o, 0);
    chk("s1_issues", n_issued, 1);
    chk("s1_acc", last_acc, 1);
    chk("s1_src", last_src, 0);
    chk("s1_bit9", last_res[9], 1);

    // Over-balance transfer is rejected without an accept pulse
    base = n_results; pulses = n_accpulse;
    rq[0].push_back(mk(1, 2, 200, 0));
    wait_res(base + 1, 100);
    chk("s2_acc", last_acc, 0);
    chk("s2_no_pulse", n_accpulse, pulses);
    chk("s2_cnt_rej", cnt_rejected_o, 1);

    // Requester 3 moves the rr pointer back to 0
    base = n_results;
    rq[3].push_back(mk(5, 6, 10, 0));
    wait_res(base + 1, 100);

    // All four requesters continuously valid, random amounts
    glog.delete();
    base = n_results;
    for (int i = 0; i < 8; i++)
      rq[i % 4].push_back(mk(8'(i), 8'(i + 1), $urandom_range(0, 200), 1'($urandom_range(0, 1))));
    wait_res(base + 8, 400);
    chk("s3_grants", glog.size(), 8);
    for (int i = 0; i < 8; i++) chk("s3_order", (glog.size() > i) ? glog[i] : -1, i % 4);

    // ack held low while ISSUE waits
    ack_hold = 1'b1;
    repeat (2) @(negedge clk);
    base = n_results; issued = n_issued;
    rq[1].push_back(mk(2, 3, 30, 0));
    c = 0;
    while (!busy_o && c < 20) begin @(negedge clk); c++; end
    chk("s4_busy", busy_o, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s4_hold", v_valid_o, 0);
    end
    chk("s4_no_issue", n_issued, issued);
    ack_hold = 1'b0;
    c = 0;
    while (n_issued == issued && c < 4) begin @(negedge clk); c++; end
    chk("s4_issue", n_issued, issued + 1);
    wait_res(base + 1, 100);

    // Validator hang triggers the watchdog
    v_hang = 1'b1;
    base = n_results;
    rq[2].push_back(mk(7, 8, 10, 0));
    wait_res(base + 1, TO + 40);
    chk("s5_timeout", timeout_o, 1);
    chk("s5_acc", last_acc, 0);
    total++;
    assert ((result_cyc - issue_cyc) >= TO - 1 && (result_cyc - issue_cyc) <= TO + 2) else begin
      bad++;
      $error("FAIL s5_latency: got %0d expected about %0d", result_cyc - issue_cyc, TO);
    end
    v_hang = 1'b0;
    base = n_results;
    rq[2].push_back(mk(9, 9, 20, 0));
    wait_res(base + 1, 100);
    chk("s5_resume_acc", last_acc, 1);
    chk("s5_sticky", timeout_o, 1);

    // enable low blocks new grants
    set_enable(1'b0);
    issued = n_issued; base = n_results;
    rq[3].push_back(mk(4, 4, 40, 0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("s6_no_grant", req_ready_o, 0);
    end
    chk("s6_idle", busy_o, 0);
    set_enable(1'b1);
    wait_res(base + 1, 100);

    // Random traffic across requesters
    base = n_results;
    for (int i = 0; i < 12; i++)
      rq[$urandom_range(0, 3)].push_back(mk(8'($urandom), 8'($urandom), $urandom_range(0, 200), 1'($urandom_range(0, 1))));
    wait_res(base + 12, 1200);

    // Async reset in WAIT_DONE abandons the transfer
    issued = n_issued;
    rq[0].push_back(mk(1, 1, 10, 0));
    c = 0;
    while (!(n_issued > issued && !v_ack_i) && c < 60) begin @(negedge clk); c++; end
    @(negedge clk);
    chk("s7_in_wait", busy_o, 1);
    #2 rst = 1'b1;
    #1 chk_reset("s7");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    glog.delete();
    for (int k = 0; k < N; k++) rq[k].push_back(mk(8'(k), 8'(k), 10, 0));
    wait_res(4, 400);
    chk("s7_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);
    chk("s7_cnt_acc", cnt_accepted_o, 4);

    // Saturation of the accepted counter
    @(negedge clk);
    force dut.cnt_accepted_o = 32'hFFFF_FFFF;
    m_acc = 32'hFFFF_FFFF;
    #1 release dut.cnt_accepted_o;
    chk("s8_forced", cnt_accepted_o, 32'hFFFF_FFFF);
    base = n_results;
    rq[1].push_back(mk(3, 3, 15, 0));
    wait_res(base + 1, 100);
    chk("s8_acc", last_acc, 1);
    chk("s8_saturated", cnt_accepted_o, 32'hFFFF_FFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trans_arbiter.md
Name: trans_arbiter

Overview:
- Shares one trans_validator between N transaction sources.
- Round-robin arbitrates the requesters and latches the granted 128-bit transaction.
- Issues it to the validator using the validator's ack-level handshake, then waits for the validator to finish.
- Reports per-transaction outcome (accepted/rejected), requester id and running statistics, plus a hang watchdog.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- TIMEOUT, 32768, max cycles from issue to validator-idle before timeout is flagged.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- enable_i  in  1  allow new grants; an in-flight transaction always completes
- req_valid_i  in  N_REQ  per-requester transaction available
- req_data_i  in  128*N_REQ  per-requester transaction; requester k at [128k+127:128k]
- req_ready_o  out  N_REQ  one-hot pulse: transaction k consumed this cycle
- v_data_o  out  128  transaction to the validator's data_i
- v_valid_o  out  1  to the validator's valid_i
- v_ack_i  in  1  from the validator's ack_o; high means the validator is idle and sampling
- v_accept_i  in  1  from the validator's valid_o; pulse means the transaction was accepted
- res_valid_o  out  1  one-cycle outcome pulse
- res_accepted_o  out  1  1 = accepted, 0 = rejected
- res_src_o  out  $clog2(N_REQ)  originating requester
- res_data_o  out  128  the transaction just resolved
- busy_o  out  1  high in every state except IDLE
- timeout_o  out  1  sticky; cleared only by rst
- cnt_accepted_o  out  32  saturating count of accepted transactions
- cnt_rejected_o  out  32  saturating count of rejected transactions

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state = IDLE; rr pointer = 0.
  - All outputs 0, including counters and timeout_o.
  - An in-flight transaction is abandoned with no result pulse.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If enable_i and any req_valid_i: grant the first requester with valid set, searching from rr pointer upward with wrap (N_REQ-1 -> 0).
  - In that cycle's registered update: req_ready_o[k] = 1 for exactly one cycle, latch req_data_i[k] and k, rr pointer = k+1 mod N_REQ, state -> ISSUE.
  - At most one req_ready_o bit is high in any cycle.
  - If no requester is valid, the rr pointer is unchanged.
- ISSUE:
  - v_valid_o = 1 and v_data_o = latched data only in a cycle where v_ack_i = 1; then -> WAIT_BUSY.
  - While v_ack_i = 0, v_valid_o stays 0 and the block stays in ISSUE.
  - v_valid_o is never high for more than one cycle per transaction.
- WAIT_BUSY:
  - Waits for v_ack_i = 0. The validator's ack is registered, so it stays high for one cycle after capture; that cycle must not be read as completion.
  - On v_ack_i = 0 -> WAIT_DONE.
- WAIT_DONE:
  - Any v_accept_i pulse seen in WAIT_BUSY or WAIT_DONE sets an internal accepted flag.
  - When v_ack_i = 1 (validator back idle and memory writes done): one-cycle res_valid_o, res_accepted_o = flag, res_src_o, res_data_o; flag clears; state -> IDLE.
- Counters:
  - On a result pulse, increment cnt_accepted_o or cnt_rejected_o.
  - Both saturate at 0xFFFFFFFF with no wrap.
- Throughput: a new grant may occur in the same cycle the result pulse is issued. The IDLE state is entered at that edge, so the minimum gap from a result to the next v_valid_o is 2 cycles.
- Watchdog:
  - Cycle counter clears on entry to WAIT_BUSY and counts in WAIT_BUSY and WAIT_DONE.
  - On reaching TIMEOUT: set timeout_o, emit a result with res_accepted_o = 0, count it as rejected, and return to IDLE.
- Block-start (data bit 9) is forwarded unchanged; no reordering, so per-requester order is preserved.
- enable_i deasserted only blocks new grants in IDLE.
- Requester data must be held stable while its valid is high, until ready.

Test Plan:
- Single requester 0, data ids S=1, R=2, amount=50, bit9=1, validator model accepts:
  - v_valid_o is exactly one cycle, only while v_ack_i=1.
  - Result: res_accepted_o=1, src=0; cnt_accepted_o=1.
- Amount=200 with fresh accounts (balance 100), validator rejects:
  - No v_accept_i; result res_accepted_o=0; cnt_rejected_o=1.
- All 4 requesters valid continuously, 8 transactions:
  - Grant order 0,1,2,3,0,1,2,3; one ready bit per grant.
  - No new v_valid_o until the previous result pulse.
- v_ack_i held low for 10 cycles while in ISSUE -> v_valid_o stays 0; issues on the first ack-high cycle.
- Validator model hangs with ack low, TIMEOUT=64:
  - After 64 cycles, timeout_o=1 (sticky) and a reject result is emitted.
  - Arbitration resumes afterward.
- rst asserted asynchronously in WAIT_DONE:
  - All outputs 0 immediately, no result pulse.
  - Next grant starts from requester 0.
  - Counter saturation is checked by forcing the count to 0xFFFFFFFF, then one more accept leaves it unchanged.
